// File: rtl/decode_stage.sv
// D stage of the 5-stage MIPS pipeline: GPR file with W bypass, RS/RT forwarding,
// branch/jump resolution and the D/E pipeline register (bubble on stall).

module decode_opnd (
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_rf,
    input  logic [31:0] i_fwd_e,
    input  logic [31:0] i_fwd_m,
    output logic [31:0] o_val
);
    // Select 3 is reserved and falls back to the register file.
    always_comb begin
        unique case (i_sel)
            2'd1:    o_val = i_fwd_m;
            2'd2:    o_val = i_fwd_e;
            default: o_val = i_rf;
        endcase
    end
endmodule

module decode_stage #(
    parameter logic [31:0] RESET_PC4 = 32'h0000_3004,
    parameter int          REG_COUNT = 32
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] IRD,
    input  logic [31:0] PC4D,
    input  logic        PauseD,
    input  logic [1:0]  FwdSelRS,
    input  logic [1:0]  FwdSelRT,
    input  logic [31:0] FwdDataE,
    input  logic [31:0] FwdDataM,
    input  logic        RegWE_W,
    input  logic [4:0]  A3_W,
    input  logic [31:0] WD_W,
    output logic [31:0] NPC,
    output logic [1:0]  PCsrc,
    output logic        Branch,
    output logic [31:0] RS_D_OUT,
    output logic [31:0] IRE,
    output logic [31:0] PC4E,
    output logic [31:0] RS_E,
    output logic [31:0] RT_E,
    output logic [31:0] EXT_E
);
    localparam int NOPND = 2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [1:0] PC_SEQ = 2'd0;
    localparam logic [1:0] PC_BR  = 2'd1;
    localparam logic [1:0] PC_J   = 2'd2;
    localparam logic [1:0] PC_JR  = 2'd3;

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc4;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
    } de_t;

    logic [31:0] r_gpr [REG_COUNT];
    de_t         r_de;
    de_t         w_de_nxt;

    logic [NOPND-1:0][4:0]  w_addr;
    logic [NOPND-1:0][1:0]  w_sel;
    logic [NOPND-1:0][31:0] w_rf;
    logic [NOPND-1:0][31:0] w_opnd;

    logic [5:0]  w_op;
    logic [5:0]  w_fn;
    logic [15:0] w_imm;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_ext;
    logic [31:0] w_npc;
    logic [1:0]  w_pcsrc;
    logic        w_branch;
    logic        w_eq;

    assign w_addr[0] = IRD[25:21];
    assign w_addr[1] = IRD[20:16];
    assign w_sel[0]  = FwdSelRS;
    assign w_sel[1]  = FwdSelRT;

    // Register read with same-cycle W bypass, then the forward mux.
    for (genvar g = 0; g < NOPND; g++) begin : g_opnd
        assign w_rf[g] = (w_addr[g] == 5'd0)                    ? 32'd0 :
                         (RegWE_W && (A3_W == w_addr[g]))       ? WD_W  :
                                                                  r_gpr[w_addr[g]];
        decode_opnd u_opnd (
            .i_sel   (w_sel[g]),
            .i_rf    (w_rf[g]),
            .i_fwd_e (FwdDataE),
            .i_fwd_m (FwdDataM),
            .o_val   (w_opnd[g])
        );
    end

    assign w_op     = IRD[31:26];
    assign w_fn     = IRD[5:0];
    assign w_imm    = IRD[15:0];
    assign w_br_tgt = PC4D + {{14{w_imm[15]}}, w_imm, 2'b00};
    assign w_j_tgt  = {PC4D[31:28], IRD[25:0], 2'b00};
    assign w_eq     = (w_opnd[0] == w_opnd[1]);

    always_comb begin
        w_npc    = PC4D;
        w_pcsrc  = PC_SEQ;
        w_branch = 1'b0;
        case (w_op)
            OP_BEQ: begin
                w_npc    = w_br_tgt;
                w_branch = w_eq;
            end
            OP_BNE: begin
                w_npc    = w_br_tgt;
                w_branch = !w_eq;
            end
            OP_J, OP_JAL: begin
                w_npc   = w_j_tgt;
                w_pcsrc = PC_J;
            end
            OP_RTYPE: begin
                if (w_fn == FN_JR) w_pcsrc = PC_JR;
            end
            default: ;
        endcase
        if (w_branch) w_pcsrc = PC_BR;
        // A stalled D instruction must not redirect fetch; NPC is left as computed.
        if (PauseD) begin
            w_pcsrc  = PC_SEQ;
            w_branch = 1'b0;
        end
    end

    always_comb begin
        case (w_op)
            OP_ANDI, OP_ORI, OP_XORI: w_ext = {16'd0, w_imm};
            OP_LUI:                   w_ext = {w_imm, 16'd0};
            default:                  w_ext = {{16{w_imm[15]}}, w_imm};
        endcase
    end

    always_comb begin
        w_de_nxt.ir  = IRD;
        w_de_nxt.pc4 = PC4D;
        w_de_nxt.rs  = w_opnd[0];
        w_de_nxt.rt  = w_opnd[1];
        w_de_nxt.ext = w_ext;
        if (PauseD) begin
            w_de_nxt.ir  = 32'd0;
            w_de_nxt.rs  = 32'd0;
            w_de_nxt.rt  = 32'd0;
            w_de_nxt.ext = 32'd0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < REG_COUNT; i++) r_gpr[i] <= 32'd0;
        end else if (RegWE_W && (A3_W != 5'd0)) begin
            r_gpr[A3_W] <= WD_W;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_de.ir  <= 32'd0;
            r_de.pc4 <= RESET_PC4;
            r_de.rs  <= 32'd0;
            r_de.rt  <= 32'd0;
            r_de.ext <= 32'd0;
        end else begin
            r_de <= w_de_nxt;
        end
    end

    assign NPC      = w_npc;
    assign PCsrc    = w_pcsrc;
    assign Branch   = w_branch;
    assign RS_D_OUT = w_opnd[0];
    assign IRE      = r_de.ir;
    assign PC4E     = r_de.pc4;
    assign RS_E     = r_de.rs;
    assign RT_E     = r_de.rt;
    assign EXT_E    = r_de.ext;
endmodule
